pipelined_datapath_fwd: RTL and testbench
=========================================

PIPELINED_DATAPATH_FWD -- requirements
Module: pipelined_datapath_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data/register width.
REQ-002 SHALL have parameter I_ADDR_BITS, default 6, meaning instruction address width.
REQ-003 SHALL have parameter D_ADDR_BITS, default 6, meaning data address width.
REQ-004 SHALL have parameter FWD_EN, default 1, meaning 1 = forwarding enabled, 0 = stall-only hazard resolution.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-006 Control inputs from the UC, sampled in ID: rf_we, rf_src, ula_src, branch, d_mem_we_in, d_mem_re_in  input  1 each; ula_cmd  input  3.
REQ-007 i_mem_data  input  32  instruction at i_mem_addr; i_mem_addr  output  I_ADDR_BITS  low bits of PC.
REQ-008 d_mem_rdata  input  XLEN  load data; d_mem_wdata  output  XLEN  store data; d_mem_addr  output  D_ADDR_BITS  low bits of MEM-stage ALU result; d_mem_we, d_mem_re  output  1 each.
REQ-009 opcode  output  7, func3  output  3, func7b5  output  1: fields of the ID instruction.
REQ-010 zero  output  1  EX-stage ULA zero flag; stall  output  1  hazard stall this cycle; flush  output  1  taken-branch flush this cycle.

Function
REQ-011 SHALL implement five stages (IF, ID, EX, MEM, WB) separated by IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-012 IF: PC advances by 4 each cycle unless stalled or redirected.
REQ-013 Branch target = ID/EX PC + (imm << 1), computed in EX, registered into EX/MEM; taken = branch & zero, evaluated in MEM.
REQ-014 Taken branch: next PC = target; flush = 1; IF/ID, ID/EX and EX/MEM load bubbles (all control bits 0, instruction = 32'h00000013) on the same edge; branch penalty = 3 cycles.
REQ-015 Register file: x0 reads 0 and ignores writes; a WB write to the register being read in ID SHALL be visible to ID in the same cycle (write-through bypass).
REQ-016 FWD_EN=1: EX operand rs1/rs2 SHALL be taken from EX/MEM ALU result when the MEM instruction has rf_we=1, rd!=0, rd==rs; else from the WB write value when the WB instruction has rf_we=1, rd!=0, rd==rs; else from ID/EX. MEM has priority over WB.
REQ-017 Store data (d_mem_wdata) SHALL use the forwarded rs2 value, not the raw ID/EX value.
REQ-018 Load-use (FWD_EN=1): EX has d_mem_re=1, rd!=0, rd equal to ID rs1 or rs2 -> stall=1 for exactly 1 cycle: PC and IF/ID hold, ID/EX loads a bubble.
REQ-019 FWD_EN=0: stall=1 while any of EX or MEM holds rf_we=1, rd!=0, rd matching ID rs1/rs2; with REQ-015 the maximum RAW stall is 2 cycles.
REQ-020 Hazard checks SHALL compare rs2 only for opcodes that read rs2 (R-type, store, branch) and rs1 for all except LUI/AUIPC/JAL.
REQ-021 Flush and stall in the same cycle: flush wins; PC takes branch target, stall output still reflects the hazard for that cycle, no hold occurs.
REQ-022 WB value = d_mem_rdata registered in MEM/WB when rf_src=1, else ALU result.
REQ-023 d_mem_we/d_mem_re SHALL be 0 for bubbles; memory outputs change only with EX/MEM register contents.
REQ-024 Arithmetic is XLEN bits, wrap-around, no overflow flag; PC is XLEN bits, i_mem_addr its low I_ADDR_BITS.

Reset
REQ-025 With rst=1 at a rising edge: PC=0, all pipeline registers cleared to bubbles, all register file entries 0.
REQ-026 During and after reset until the first instruction reaches MEM: d_mem_we=0, d_mem_re=0, stall=0, flush=0, i_mem_addr=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight instructions; no register-file or memory write occurs on that edge.

Verification
REQ-028 Forward chain, FWD_EN=1: addi x1,x0,5; add x2,x1,x1; add x3,x2,x1 -> x2=10, x3=15, stall never asserted.
REQ-029 Load-use: mem[8]=0x2A; ld x4,8(x0); add x5,x4,x4 -> stall=1 exactly one cycle, x5=0x54.
REQ-030 Taken branch at PC 0x10, imm 4 (target 0x18): beq x0,x0 -> flush=1 one cycle, the 3 following instructions never write, next fetch 0x18.
REQ-031 FWD_EN=0, same chain as REQ-028 -> x2=10, x3=15, total 2 stall cycles per dependent pair.
REQ-032 x0 target: addi x0,x0,7; add x6,x0,x0 -> x6=0, no forwarding from x0.
REQ-033 Reset mid-run after 3 instructions issued -> PC=0 next cycle, no writes from the discarded instructions, all outputs at reset values.

Source files
------------

// File: rtl/pipelined_datapath_fwd.sv
// Five-stage in-order integer datapath (IF/ID/EX/MEM/WB) with EX-stage operand
// forwarding, load-use / RAW stall control and branch resolution in MEM.
module pipelined_datapath_fwd #(
  parameter int XLEN        = 64,
  parameter int I_ADDR_BITS = 6,
  parameter int D_ADDR_BITS = 6,
  parameter bit FWD_EN      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rf_we,
  input  logic                   rf_src,
  input  logic                   ula_src,
  input  logic                   branch,
  input  logic                   d_mem_we_in,
  input  logic                   d_mem_re_in,
  input  logic [2:0]             ula_cmd,
  input  logic [31:0]            i_mem_data,
  output logic [I_ADDR_BITS-1:0] i_mem_addr,
  input  logic [XLEN-1:0]        d_mem_rdata,
  output logic [XLEN-1:0]        d_mem_wdata,
  output logic [D_ADDR_BITS-1:0] d_mem_addr,
  output logic                   d_mem_we,
  output logic                   d_mem_re,
  output logic [6:0]             opcode,
  output logic [2:0]             func3,
  output logic                   func7b5,
  output logic                   zero,
  output logic                   stall,
  output logic                   flush
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

  typedef struct packed {
    logic            rf_we, rf_src, ula_src, branch, mem_we, mem_re;
    logic [2:0]      ula_cmd;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] pc, a, b, imm;
  } idex_t;

  typedef struct packed {
    logic            rf_we, rf_src, branch, mem_we, mem_re, zero;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu, wdata, target;
  } exmem_t;

  typedef struct packed {
    logic            rf_we, rf_src;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu, rdata;
  } memwb_t;

  localparam ifid_t IFID_BUBBLE = '{pc: '0, instr: NOP};

  logic [XLEN-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  idex_t           idex_q, idex_d;
  exmem_t          exmem_q, exmem_d;
  memwb_t          memwb_q, memwb_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic [31:0]     id_instr;
  logic [4:0]      id_rs1, id_rs2;
  logic            uses_rs1, uses_rs2;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  logic [XLEN-1:0] wb_val, ex_a, ex_rs2, ex_b, ex_alu;
  logic            wb_wr, mem_fwd_ok, wb_fwd_ok;
  logic            ex_match, mem_match, hazard, taken;

  assign id_instr = ifid_q.instr;
  assign opcode   = id_instr[6:0];
  assign func3    = id_instr[14:12];
  assign func7b5  = id_instr[30];
  assign id_rs1   = id_instr[19:15];
  assign id_rs2   = id_instr[24:20];
  assign uses_rs1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};

  // B-type immediate is kept in halfword units; EX scales it when forming the target.
  always_comb begin
    case (opcode)
      7'b0100011: id_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      7'b1100011: id_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31], id_instr[7],
                            id_instr[30:25], id_instr[11:8]};
      default:    id_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    endcase
  end

  assign wb_val = memwb_q.rf_src ? memwb_q.rdata : memwb_q.alu;
  assign wb_wr  = memwb_q.rf_we && (memwb_q.rd != 5'd0);

  // Register read with write-through so a WB write is seen by ID in the same cycle.
  always_comb begin
    id_a = (id_rs1 == 5'd0) ? '0 : rf_q[id_rs1];
    id_b = (id_rs2 == 5'd0) ? '0 : rf_q[id_rs2];
    if (wb_wr && (memwb_q.rd == id_rs1)) id_a = wb_val;
    if (wb_wr && (memwb_q.rd == id_rs2)) id_b = wb_val;
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_wr) rf_d[memwb_q.rd] = wb_val;
  end

  assign mem_fwd_ok = FWD_EN && exmem_q.rf_we && (exmem_q.rd != 5'd0);
  assign wb_fwd_ok  = FWD_EN && wb_wr;

  always_comb begin
    ex_a = idex_q.a;
    if (mem_fwd_ok && (exmem_q.rd == idex_q.rs1))     ex_a = exmem_q.alu;
    else if (wb_fwd_ok && (memwb_q.rd == idex_q.rs1)) ex_a = wb_val;
    ex_rs2 = idex_q.b;
    if (mem_fwd_ok && (exmem_q.rd == idex_q.rs2))     ex_rs2 = exmem_q.alu;
    else if (wb_fwd_ok && (memwb_q.rd == idex_q.rs2)) ex_rs2 = wb_val;
  end

  assign ex_b = idex_q.ula_src ? idex_q.imm : ex_rs2;

  always_comb begin
    case (idex_q.ula_cmd)
      3'd0:    ex_alu = ex_a + ex_b;
      3'd1:    ex_alu = ex_a - ex_b;
      3'd2:    ex_alu = ex_a & ex_b;
      3'd3:    ex_alu = ex_a | ex_b;
      3'd4:    ex_alu = ex_a ^ ex_b;
      3'd5:    ex_alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      3'd6:    ex_alu = ex_a << ex_b[SHW-1:0];
      default: ex_alu = ex_a >> ex_b[SHW-1:0];
    endcase
  end

  assign zero = (ex_alu == '0);

  // Producer hazards against the instruction in ID; only registers it really reads count.
  assign ex_match  = (idex_q.rd != 5'd0) &&
                     ((uses_rs1 && idex_q.rd == id_rs1) || (uses_rs2 && idex_q.rd == id_rs2));
  assign mem_match = (exmem_q.rd != 5'd0) &&
                     ((uses_rs1 && exmem_q.rd == id_rs1) || (uses_rs2 && exmem_q.rd == id_rs2));
  assign hazard = FWD_EN ? (idex_q.mem_re && ex_match)
                         : ((idex_q.rf_we && ex_match) || (exmem_q.rf_we && mem_match));
  assign taken  = exmem_q.branch && exmem_q.zero;

  always_comb begin
    pc_d         = pc_q + XLEN'(4);
    ifid_d.pc    = pc_q;
    ifid_d.instr = i_mem_data;

    idex_d.rf_we   = rf_we;
    idex_d.rf_src  = rf_src;
    idex_d.ula_src = ula_src;
    idex_d.branch  = branch;
    idex_d.mem_we  = d_mem_we_in;
    idex_d.mem_re  = d_mem_re_in;
    idex_d.ula_cmd = ula_cmd;
    idex_d.rd      = id_instr[11:7];
    idex_d.rs1     = id_rs1;
    idex_d.rs2     = id_rs2;
    idex_d.pc      = ifid_q.pc;
    idex_d.a       = id_a;
    idex_d.b       = id_b;
    idex_d.imm     = id_imm;

    exmem_d.rf_we  = idex_q.rf_we;
    exmem_d.rf_src = idex_q.rf_src;
    exmem_d.branch = idex_q.branch;
    exmem_d.mem_we = idex_q.mem_we;
    exmem_d.mem_re = idex_q.mem_re;
    exmem_d.zero   = zero;
    exmem_d.rd     = idex_q.rd;
    exmem_d.alu    = ex_alu;
    exmem_d.wdata  = ex_rs2;
    exmem_d.target = idex_q.pc + (idex_q.imm << 1);

    memwb_d.rf_we  = exmem_q.rf_we;
    memwb_d.rf_src = exmem_q.rf_src;
    memwb_d.rd     = exmem_q.rd;
    memwb_d.alu    = exmem_q.alu;
    memwb_d.rdata  = d_mem_rdata;

    // A taken branch overrides any stall: redirect and squash the three younger stages.
    if (taken) begin
      pc_d    = exmem_q.target;
      ifid_d  = IFID_BUBBLE;
      idex_d  = '0;
      exmem_d = '0;
    end else if (hazard) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ifid_q  <= IFID_BUBBLE;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      rf_q    <= rf_d;
    end
  end

  // Strobes are masked while reset is held so the reset edge never writes memory.
  assign i_mem_addr  = rst ? '0 : pc_q[I_ADDR_BITS-1:0];
  assign d_mem_addr  = exmem_q.alu[D_ADDR_BITS-1:0];
  assign d_mem_wdata = exmem_q.wdata;
  assign d_mem_we    = exmem_q.mem_we && !rst;
  assign d_mem_re    = exmem_q.mem_re && !rst;
  assign stall       = hazard && !rst;
  assign flush       = taken && !rst;

endmodule

// File: tb/tb_pipelined_datapath_fwd.sv
// Runs identical programs on a forwarding instance and a stall-only instance,
// acting as the control unit and memories, and checks architectural results.
`timescale 1ns/1ps
module tb_pipelined_datapath_fwd;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic       rf_we, rf_src, ula_src, branch, mwe, mre;
    logic [2:0] cmd;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  f3;
    logic        f7b5;
    logic [63:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        load_mem;
  logic [31:0] imem [16];
  logic [63:0] dmem_init [8];
  int          checks;
  int          failures;
  int          stall_cnt [2];
  int          flush_cnt [2];
  logic        prev_flush [2];
  logic [5:0]  post_flush_addr [2];
  vec_t        vecs [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control unit: decodes the ID fields the datapath exposes.
  function automatic ctrl_t uc(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R: begin
        c.rf_we = 1'b1;
        case (f3)
          3'b000:  c.cmd = f7 ? 3'd1 : 3'd0;
          3'b111:  c.cmd = 3'd2;
          3'b110:  c.cmd = 3'd3;
          3'b100:  c.cmd = 3'd4;
          3'b010:  c.cmd = 3'd5;
          3'b001:  c.cmd = 3'd6;
          default: c.cmd = 3'd7;
        endcase
      end
      OP_IMM: begin c.rf_we = 1'b1; c.ula_src = 1'b1; end
      OP_LD:  begin c.rf_we = 1'b1; c.rf_src = 1'b1; c.ula_src = 1'b1; c.mre = 1'b1; end
      OP_ST:  begin c.ula_src = 1'b1; c.mwe = 1'b1; end
      OP_BR:  begin c.branch = 1'b1; c.cmd = 3'd1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    logic [5:0]  imaddr;
    logic [31:0] idata;
    logic [63:0] drdata, dwdata;
    logic [5:0]  daddr;
    logic        dwe, dre, zero, stall, flush, f7b5;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    ctrl_t       ctrl;
    logic [63:0] dmem [8];

    always_comb ctrl = uc(opcode, func3, f7b5);
    assign idata  = imem[imaddr[5:2]];
    assign drdata = dmem[daddr[5:3]];

    always @(posedge clk) begin
      if (load_mem) begin
        for (int k = 0; k < 8; k++) dmem[k] <= dmem_init[k];
      end else if (dwe) begin
        dmem[daddr[5:3]] <= dwdata;
      end
    end

    pipelined_datapath_fwd #(
      .XLEN(64), .I_ADDR_BITS(6), .D_ADDR_BITS(6), .FWD_EN(g == 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .rf_we(ctrl.rf_we), .rf_src(ctrl.rf_src), .ula_src(ctrl.ula_src),
      .branch(ctrl.branch), .d_mem_we_in(ctrl.mwe), .d_mem_re_in(ctrl.mre),
      .ula_cmd(ctrl.cmd), .i_mem_data(idata), .i_mem_addr(imaddr),
      .d_mem_rdata(drdata), .d_mem_wdata(dwdata), .d_mem_addr(daddr),
      .d_mem_we(dwe), .d_mem_re(dre), .opcode(opcode), .func3(func3),
      .func7b5(f7b5), .zero(zero), .stall(stall), .flush(flush)
    );
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic f7b5, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_ST};
  endfunction

  // imm is in halfword units: target = pc + (imm << 1).
  function automatic logic [31:0] enc_b(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], OP_BR};
  endfunction

  function automatic logic [63:0] reg_of(input int d, input logic [4:0] r);
    return (d == 0) ? g_dut[0].u_dut.rf_q[r] : g_dut[1].u_dut.rf_q[r];
  endfunction

  task automatic clear_program();
    for (int i = 0; i < 16; i++) imem[i] = NOP;
    for (int i = 0; i < 8; i++) dmem_init[i] = '0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (prev_flush[0]) post_flush_addr[0] = g_dut[0].imaddr;
      if (prev_flush[1]) post_flush_addr[1] = g_dut[1].imaddr;
      prev_flush[0] = g_dut[0].flush;
      prev_flush[1] = g_dut[1].flush;
      if (g_dut[0].stall) stall_cnt[0]++;
      if (g_dut[1].stall) stall_cnt[1]++;
      if (g_dut[0].flush) flush_cnt[0]++;
      if (g_dut[1].flush) flush_cnt[1]++;
    end
  endtask

  // Reset both pipelines, load data memory, then run the loaded program n cycles.
  task automatic applyStimulus(input int n);
    rst = 1'b1;
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      stall_cnt[d] = 0;
      flush_cnt[d] = 0;
      prev_flush[d] = 1'b0;
      post_flush_addr[d] = 6'h3F;
    end
    run_cycles(n);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    load_mem = 1'b0;
    clear_program();

    vecs[0] = '{"add",      12'd5,   12'd7,  3'b000, 1'b0, 64'd12};
    vecs[1] = '{"sub_wrap", 12'd5,   12'd7,  3'b000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{"and",      12'h0F0, 12'h03C, 3'b111, 1'b0, 64'h30};
    vecs[3] = '{"or",       12'h0F0, 12'h03C, 3'b110, 1'b0, 64'hFC};
    vecs[4] = '{"xor",      12'h0F0, 12'h03C, 3'b100, 1'b0, 64'hCC};
    vecs[5] = '{"slt_neg",  12'hFFF, 12'd1,  3'b010, 1'b0, 64'd1};
    vecs[6] = '{"sll_63",   12'd1,   12'd63, 3'b001, 1'b0, 64'h8000_0000_0000_0000};
    vecs[7] = '{"srl_60",   12'hFFF, 12'd60, 3'b101, 1'b0, 64'hF};
    vecs[8] = '{"add_wrap", 12'hFFF, 12'd1,  3'b000, 1'b0, 64'd0};

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_imaddr", 64'(g_dut[0].imaddr), 64'h0);
    checkOutput("rst_dwe",    64'(g_dut[0].dwe),    64'h0);
    checkOutput("rst_dre",    64'(g_dut[0].dre),    64'h0);
    checkOutput("rst_stall",  64'(g_dut[0].stall),  64'h0);
    checkOutput("rst_flush",  64'(g_dut[1].flush),  64'h0);

    // x1 reaches the R-op from WB and x2 from MEM on the forwarding instance.
    for (int t = 0; t < 9; t++) begin
      clear_program();
      imem[0] = enc_i(vecs[t].a, 5'd0, 3'b000, 5'd1, OP_IMM);
      imem[1] = enc_i(vecs[t].b, 5'd0, 3'b000, 5'd2, OP_IMM);
      imem[2] = enc_r(vecs[t].f7b5, 5'd2, 5'd1, vecs[t].f3, 5'd3);
      applyStimulus(14);
      checkOutput({vecs[t].name, "_fwd"},   reg_of(0, 5'd3), vecs[t].exp);
      checkOutput({vecs[t].name, "_stall"}, reg_of(1, 5'd3), vecs[t].exp);
    end

    clear_program();
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[1] = enc_r(1'b0, 5'd1, 5'd1, 3'b000, 5'd2);
    imem[2] = enc_r(1'b0, 5'd1, 5'd2, 3'b000, 5'd3);
    applyStimulus(16);
    checkOutput("chain_x2_fwd",     reg_of(0, 5'd2), 64'd10);
    checkOutput("chain_x3_fwd",     reg_of(0, 5'd3), 64'd15);
    checkOutput("chain_stall_fwd",  64'(stall_cnt[0]), 64'd0);
    checkOutput("chain_x2_nofwd",   reg_of(1, 5'd2), 64'd10);
    checkOutput("chain_x3_nofwd",   reg_of(1, 5'd3), 64'd15);
    checkOutput("chain_stall_nofwd", 64'(stall_cnt[1]), 64'd4);

    clear_program();
    dmem_init[1] = 64'h2A;
    imem[0] = enc_i(12'd8, 5'd0, 3'b011, 5'd4, OP_LD);
    imem[1] = enc_r(1'b0, 5'd4, 5'd4, 3'b000, 5'd5);
    imem[2] = enc_s(12'd16, 5'd5, 5'd0, 3'b011);
    applyStimulus(16);
    checkOutput("ld_x4_fwd",       reg_of(0, 5'd4), 64'h2A);
    checkOutput("ld_x5_fwd",       reg_of(0, 5'd5), 64'h54);
    checkOutput("ld_stall_fwd",    64'(stall_cnt[0]), 64'd1);
    checkOutput("st_fwd_data",     g_dut[0].dmem[2], 64'h54);
    checkOutput("ld_x5_nofwd",     reg_of(1, 5'd5), 64'h54);
    checkOutput("ld_stall_nofwd",  64'(stall_cnt[1]), 64'd4);
    checkOutput("st_nofwd_data",   g_dut[1].dmem[2], 64'h54);

    clear_program();
    imem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[4] = enc_b(12'd4, 5'd0, 5'd0, 3'b000);
    imem[5] = enc_i(12'd7, 5'd0, 3'b000, 5'd7, OP_IMM);
    imem[6] = enc_i(12'd8, 5'd0, 3'b000, 5'd8, OP_IMM);
    imem[7] = enc_i(12'd9, 5'd0, 3'b000, 5'd9, OP_IMM);
    applyStimulus(14);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("br_flush_cnt_%0d", d),  64'(flush_cnt[d]), 64'd1);
      checkOutput($sformatf("br_next_fetch_%0d", d), 64'(post_flush_addr[d]), 64'h18);
      checkOutput($sformatf("br_x7_squashed_%0d", d), reg_of(d, 5'd7), 64'd0);
      checkOutput($sformatf("br_x8_target_%0d", d),   reg_of(d, 5'd8), 64'd8);
    end

    clear_program();
    imem[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd6, OP_IMM);
    imem[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_IMM);
    imem[2] = enc_r(1'b0, 5'd0, 5'd0, 3'b000, 5'd6);
    applyStimulus(12);
    checkOutput("x0_x6_fwd",   reg_of(0, 5'd6), 64'd0);
    checkOutput("x0_x6_nofwd", reg_of(1, 5'd6), 64'd0);
    checkOutput("x0_stays0",   reg_of(0, 5'd0), 64'd0);

    // Reset lands on the edge where a store sits in MEM and an addi sits in WB.
    clear_program();
    dmem_init[2] = 64'h77;
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
    imem[1] = enc_i(12'd6, 5'd0, 3'b000, 5'd2, OP_IMM);
    imem[2] = enc_s(12'd16, 5'd0, 5'd0, 3'b011);
    applyStimulus(5);
    checkOutput("mid_x1_before", reg_of(0, 5'd1), 64'd5);
    checkOutput("mid_dwe_before", 64'(g_dut[0].dwe), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_dwe_in_rst",   64'(g_dut[0].dwe), 64'd0);
    checkOutput("mid_dwe_in_rst_1", 64'(g_dut[1].dwe), 64'd0);
    checkOutput("mid_imaddr_in_rst", 64'(g_dut[0].imaddr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_imaddr_after", 64'(g_dut[0].imaddr), 64'd0);
    checkOutput("mid_dwe_after",    64'(g_dut[0].dwe), 64'd0);
    checkOutput("mid_dmem_kept",    g_dut[0].dmem[2], 64'h77);
    checkOutput("mid_dmem_kept_1",  g_dut[1].dmem[2], 64'h77);
    checkOutput("mid_x2_cleared",   reg_of(0, 5'd2), 64'd0);
    checkOutput("mid_x1_cleared",   reg_of(1, 5'd1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
